// File: rtl/charbuf_scroll.sv
// Text-mode character buffer with hardware scroll offset and a blanking fill engine.
// Latency: reads return 1 cycle after i_rd_en. Writes commit on the clock edge where they are accepted.
// Backpressure: o_wr_ready=0 while the fill engine runs; writes offered then are dropped, so the writer holds them.
//
// Ports:
//   i_clk, i_resetn                   clock, asynchronous active-low reset
//   i_wr_en/col/row/data, o_wr_ready  logical-space write port (shared RAM port with fill engine)
//   i_rd_en/col/row, o_rd_data/valid  logical-space read port, always serviced
//   i_scroll_up, i_clear_all          single-cycle commands, honoured only when idle
//   o_busy, o_top_row                 fill engine active, physical row shown as logical row 0
module charbuf_scroll #(
  parameter int                COLS_LOG2      = 6,
  parameter int                ROWS_LOG2      = 6,
  parameter int                CHAR_W         = 8,
  parameter logic [CHAR_W-1:0] FILL_CHAR      = 8'h20,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_wr_en,
  input  logic [COLS_LOG2-1:0] i_wr_col,
  input  logic [ROWS_LOG2-1:0] i_wr_row,
  input  logic [CHAR_W-1:0]    i_wr_data,
  output logic                 o_wr_ready,
  input  logic                 i_rd_en,
  input  logic [COLS_LOG2-1:0] i_rd_col,
  input  logic [ROWS_LOG2-1:0] i_rd_row,
  output logic [CHAR_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_scroll_up,
  input  logic                 i_clear_all,
  output logic                 o_busy,
  output logic [ROWS_LOG2-1:0] o_top_row
);

  localparam int AW    = COLS_LOG2 + ROWS_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [ROWS_LOG2-1:0] ROW_ONE = 1;
  localparam logic [AW-1:0]        CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL_LINE, S_FILL_ALL} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_init_pend;   // a post-reset clear is owed; behaves like a clear_all pulse
  logic [AW-1:0]         r_cnt, w_cnt_nxt;
  logic [ROWS_LOG2-1:0]  r_top_row, w_top_nxt;

  logic [CHAR_W-1:0]     r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_start_all;
  logic                  w_start_line;
  logic                  w_last_all;
  logic                  w_last_line;
  logic [ROWS_LOG2-1:0]  w_wr_prow;
  logic [ROWS_LOG2-1:0]  w_rd_prow;
  logic [ROWS_LOG2-1:0]  w_fill_prow;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_waddr;
  logic [CHAR_W-1:0]     w_mem_wdata;

  // Logical -> physical row: the add wraps modulo ROWS by width.
  assign w_wr_prow   = i_wr_row + r_top_row;
  assign w_rd_prow   = i_rd_row + r_top_row;
  // During a line fill top_row has already advanced, so the line being blanked is one behind it.
  assign w_fill_prow = r_top_row - ROW_ONE;

  assign w_busy       = (r_state != S_IDLE) || r_init_pend;
  assign w_start_all  = (r_state == S_IDLE) && (r_init_pend || i_clear_all);
  assign w_start_line = (r_state == S_IDLE) && !r_init_pend && !i_clear_all && i_scroll_up;
  assign w_last_all   = (r_cnt == '1);
  assign w_last_line  = (r_cnt[COLS_LOG2-1:0] == '1);

  // State register
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_init_pend <= CLEAR_ON_RESET;
      r_cnt       <= '0;
      r_top_row   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_pend <= 1'b0;
      r_cnt       <= w_cnt_nxt;
      r_top_row   <= w_top_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_top_nxt   = r_top_row;
    case (r_state)
      S_IDLE: begin
        if (w_start_all) begin
          w_state_nxt = S_FILL_ALL;
          w_cnt_nxt   = '0;
          w_top_nxt   = '0;
        end else if (w_start_line) begin
          w_state_nxt = S_FILL_LINE;
          w_cnt_nxt   = '0;
          w_top_nxt   = r_top_row + ROW_ONE;
        end
      end
      S_FILL_LINE: begin
        if (w_last_line) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      S_FILL_ALL: begin
        if (w_last_all) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: write-port mux between writer and fill engine
  always_comb begin
    w_mem_we    = i_wr_en && !w_busy;
    w_mem_waddr = {w_wr_prow, i_wr_col};
    w_mem_wdata = i_wr_data;
    case (r_state)
      S_FILL_LINE: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = {w_fill_prow, r_cnt[COLS_LOG2-1:0]};
        w_mem_wdata = FILL_CHAR;
      end
      S_FILL_ALL: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_cnt;
        w_mem_wdata = FILL_CHAR;
      end
      default: ;
    endcase
  end

  assign o_busy     = w_busy;
  assign o_wr_ready = !w_busy;
  assign o_top_row  = r_top_row;

  // RAM write port (contents are not reset)
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // RAM read port; nonblocking semantics give read-first behaviour on a same-cell collision
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= r_mem[{w_rd_prow, i_rd_col}];
      end
    end
  end

endmodule

// File: tb/tb_charbuf_scroll.sv
module tb_charbuf_scroll;

  logic       clk;
  logic       resetn;
  logic       wr_en;
  logic [5:0] wr_col;
  logic [5:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_en;
  logic [5:0] rd_col;
  logic [5:0] rd_row;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       scroll_up;
  logic       clear_all;
  logic       busy;
  logic [5:0] top_row;

  int n_total = 0;
  int n_bad   = 0;

  charbuf_scroll dut (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_wr_en     (wr_en),
    .i_wr_col    (wr_col),
    .i_wr_row    (wr_row),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .i_rd_en     (rd_en),
    .i_rd_col    (rd_col),
    .i_rd_row    (rd_row),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .i_scroll_up (scroll_up),
    .i_clear_all (clear_all),
    .o_busy      (busy),
    .o_top_row   (top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] c, input logic [5:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_col = c; wr_row = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] c, input logic [5:0] r, output logic [7:0] d);
    rd_en = 1'b1; rd_col = c; rd_row = r;
    tick();
    d = rd_data;
    rd_en = 1'b0;
  endtask

  // Counts sampled cycles with busy=1; bounded so a stuck engine cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 10000) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_scroll();
    scroll_up = 1'b1;
    tick();
    scroll_up = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    int         nb;
    int         bad_busy;
    int         bad_top;

    resetn = 1'b0; wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
    rd_en = 1'b0; rd_col = '0; rd_row = '0; scroll_up = 1'b0; clear_all = 1'b0;

    // Reset state and automatic clear after release
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_top_row", top_row, 0);
    resetn = 1'b1;
    tick();
    wait_idle(n);
    chk("init_fill_cycles", n, 4096);
    chk("init_wr_ready", wr_ready, 1);
    nb = 0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        do_read(6'(c), 6'(r), d);
        if (d !== 8'h20) nb++;
      end
    end
    chk("init_scan_nonblank", nb, 0);

    // Basic write then read, latency and hold
    do_write(6'd3, 6'd0, 8'h41);
    do_read(6'd3, 6'd0, d);
    chk("rd_valid_after_en", rd_valid, 1);
    chk("rd_data_A", d, 8'h41);
    tick();
    chk("rd_valid_drops", rd_valid, 0);
    chk("rd_data_holds", rd_data, 8'h41);

    // Same-cell read and write in one cycle returns old data
    wr_en = 1'b1; wr_col = 6'd3; wr_row = 6'd0; wr_data = 8'h55;
    rd_en = 1'b1; rd_col = 6'd3; rd_row = 6'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("read_first_old", rd_data, 8'h41);
    do_read(6'd3, 6'd0, d);
    chk("read_after_write_new", d, 8'h55);

    // Scroll: row 1 becomes logical row 0, old row 0 blanked as logical row 63
    do_write(6'd0, 6'd1, 8'h42);
    pulse_scroll();
    chk("scroll_top_row", top_row, 1);
    wait_idle(n);
    chk("scroll_busy_cycles", n, 64);
    do_read(6'd0, 6'd0, d);
    chk("scroll_B_at_row0", d, 8'h42);
    do_read(6'd3, 6'd63, d);
    chk("scroll_old_A_blanked", d, 8'h20);
    nb = 0;
    for (int c = 0; c < 64; c++) begin
      do_read(6'(c), 6'd63, d);
      if (d !== 8'h20) nb++;
    end
    chk("scroll_row63_nonblank", nb, 0);

    // 64 scrolls: wrap of top_row, tracked line blanked exactly when it scrolls out
    do_write(6'd7, 6'd5, 8'h5A);
    bad_busy = 0;
    bad_top  = 0;
    for (int k = 1; k <= 64; k++) begin
      pulse_scroll();
      wait_idle(n);
      if (n != 64) bad_busy++;
      if (top_row !== 6'((1 + k) % 64)) bad_top++;
      if (k <= 5) begin
        do_read(6'd7, 6'(5 - k), d);
        chk("tracked_line_kept", d, 8'h5A);
      end
      if (k == 6) begin
        do_read(6'd7, 6'd63, d);
        chk("tracked_line_blanked", d, 8'h20);
      end
      if (k == 62) chk("top_row_63", top_row, 63);
      if (k == 63) chk("top_row_wrap0", top_row, 0);
    end
    chk("multi_scroll_busy_bad", bad_busy, 0);
    chk("multi_scroll_top_bad", bad_top, 0);

    // Write and scroll in the same idle cycle: write lands at pre-scroll mapping
    wr_en = 1'b1; wr_col = 6'd9; wr_row = 6'd10; wr_data = 8'h77;
    scroll_up = 1'b1;
    tick();
    wr_en = 1'b0; scroll_up = 1'b0;
    wait_idle(n);
    chk("wr_scroll_top", top_row, 2);
    do_read(6'd9, 6'd9, d);
    chk("wr_scroll_data", d, 8'h77);

    // Scroll pulse while busy is ignored, not queued
    pulse_scroll();
    scroll_up = 1'b1;
    tick();
    scroll_up = 1'b0;
    wait_idle(n);
    chk("busy_scroll_cycles", n, 63);
    tick();
    chk("busy_scroll_top", top_row, 3);
    chk("busy_scroll_no_queue", busy, 0);

    // clear_all wins over scroll_up; held write commits when ready returns
    clear_all = 1'b1; scroll_up = 1'b1;
    tick();
    clear_all = 1'b0; scroll_up = 1'b0;
    chk("clear_top_row", top_row, 0);
    wr_en = 1'b1; wr_col = 6'd2; wr_row = 6'd2; wr_data = 8'h66;
    chk("clear_wr_ready_low", wr_ready, 0);
    wait_idle(n);
    chk("clear_busy_cycles", n, 4096);
    chk("clear_wr_ready_high", wr_ready, 1);
    tick();
    wr_en = 1'b0;
    do_read(6'd2, 6'd2, d);
    chk("held_write_committed", d, 8'h66);
    do_read(6'd9, 6'd11, d);
    chk("clear_blanked_old", d, 8'h20);
    tick();
    chk("clear_top_stays0", top_row, 0);

    // Reset in the middle of a full clear
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    repeat (100) tick();
    do_read(6'd0, 6'd0, d);
    chk("busy_read_valid", rd_valid, 1);
    chk("busy_read_data", d, 8'h20);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_top_row", top_row, 0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    wait_idle(n);
    chk("midrst_refill_cycles", n, 4096);
    do_write(6'd63, 6'd63, 8'h31);
    do_read(6'd63, 6'd63, d);
    chk("corner_cell", d, 8'h31);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
